// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM fader: channel numbering and
// decoding of the 2-bit-per-LED SoC word into per-colour on/off targets.
package led_pwm_pkg;

    localparam int N_LED = 4;
    localparam int N_CH  = 12;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } colour_e;

    function automatic int ch_r(input int i);
        return i;
    endfunction

    function automatic int ch_g(input int i);
        return N_LED + i;
    endfunction

    function automatic int ch_b(input int i);
        return 2 * N_LED + i;
    endfunction

    function automatic colour_e ch_colour(input int ch);
        colour_e c;
        case (ch / N_LED)
            0:       c = COL_R;
            1:       c = COL_G;
            default: c = COL_B;
        endcase
        return c;
    endfunction

    // Blue is lit only when both bits of the LED pair are set.
    function automatic logic target_bit(input logic [7:0] word, input int ch);
        logic r;
        logic g;
        logic res;
        int   i;
        i = ch % N_LED;
        r = word[2*i];
        g = word[2*i+1];
        case (ch_colour(ch))
            COL_R:   res = r;
            COL_G:   res = g;
            COL_B:   res = r & g;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// One colour channel: linear duty fade toward its target, period-aligned
// shadow copy of the duty, and the registered PWM compare.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fade_tick,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] tgt,
    input  logic                en,
    output logic                pwm_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS+1)'(STEP);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] shadow_q;
    logic                pwm_q;
    logic [PWM_BITS:0]   duty_ext;
    logic [PWM_BITS:0]   tgt_ext;

    // Next duty: one saturating step toward the target per fade tick.
    always_comb begin
        duty_ext = {1'b0, duty_q};
        tgt_ext  = {1'b0, tgt};
        duty_d   = duty_q;
        if (!fade_tick) begin
            duty_d = duty_q;
        end else if (duty_ext < tgt_ext) begin
            if ((tgt_ext - duty_ext) <= STEP_EXT) begin
                duty_d = tgt;
            end else begin
                duty_d = duty_q + STEP_EXT[PWM_BITS-1:0];
            end
        end else if (duty_ext > tgt_ext) begin
            if ((duty_ext - tgt_ext) <= STEP_EXT) begin
                duty_d = tgt;
            end else begin
                duty_d = duty_q - STEP_EXT[PWM_BITS-1:0];
            end
        end else begin
            duty_d = duty_q;
        end
    end

    // Duty, shadow and compare flops; shadow takes the pre-update duty at wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q   <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            duty_q <= duty_d;
            if (wrap) begin
                shadow_q <= duty_q;
            end
            pwm_q <= en & (cnt < shadow_q);
        end
    end

    assign pwm_o  = pwm_q;
    assign busy_o = (duty_d != tgt);

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: registers the SoC LED word, runs the fade prescaler and
// PWM counter, decodes per-channel targets and drives 12 dimmed LED pins.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int MAX_DUTY = 64,
    parameter int FADE_DIV = 50000,
    parameter int STEP     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  soc_led,
    input  logic        en,
    output logic [11:0] led,
    output logic        fade_busy
);

    localparam int PRESC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] ON_DUTY    = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] CNT_LAST   = {PWM_BITS{1'b1}};

    logic [7:0]          soc_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [PRESC_W-1:0]  presc_d;
    logic [PWM_BITS-1:0] cnt_q;
    logic                fade_busy_q;
    logic                fade_tick;
    logic                wrap;
    logic [PWM_BITS-1:0] tgt [N_CH];
    logic [N_CH-1:0]     pwm_vec;
    logic [N_CH-1:0]     busy_vec;

    assign fade_tick = (presc_q == PRESC_LAST);
    assign wrap      = (cnt_q == CNT_LAST);

    // Prescaler next state; with FADE_DIV=1 it sits at 0 and ticks every cycle.
    always_comb begin
        presc_d = presc_q;
        if (fade_tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // Per-channel fade targets from the registered SoC word.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            tgt[k] = '0;
            if (target_bit(soc_q, k)) begin
                tgt[k] = ON_DUTY;
            end else begin
                tgt[k] = '0;
            end
        end
    end

    // Input register, prescaler, PWM counter and aggregated busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            soc_q       <= 8'h00;
            presc_q     <= '0;
            cnt_q       <= '0;
            fade_busy_q <= 1'b0;
        end else begin
            soc_q       <= soc_led;
            presc_q     <= presc_d;
            cnt_q       <= cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
            fade_busy_q <= |busy_vec;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .fade_tick (fade_tick),
            .wrap      (wrap),
            .cnt       (cnt_q),
            .tgt       (tgt[k]),
            .en        (en),
            .pwm_o     (pwm_vec[k]),
            .busy_o    (busy_vec[k])
        );
    end

    assign led       = pwm_vec;
    assign fade_busy = fade_busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed scenarios plus random
// stimulus, compared every cycle against a time-indexed behavioural model.
module tb_led_pwm_fader;

    localparam int PB   = 4;
    localparam int MAXD = 12;
    localparam int FDIV = 4;
    localparam int STP  = 5;
    localparam int PER  = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  soc_led;
    logic        en;
    logic [11:0] led;
    logic        fade_busy;

    int n_checks;
    int n_errors;

    // reference model state
    int          t_since_rst;
    logic [7:0]  m_soc;
    int          m_duty   [12];
    int          m_shadow [12];
    logic [11:0] m_led;
    logic        m_busy;

    led_pwm_fader #(
        .PWM_BITS (PB),
        .MAX_DUTY (MAXD),
        .FADE_DIV (FDIV),
        .STEP     (STP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .soc_led   (soc_led),
        .en        (en),
        .led       (led),
        .fade_busy (fade_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tgt_of(input logic [7:0] w, input int k);
        int  i;
        bit  r;
        bit  g;
        bit  on;
        i  = k % 4;
        r  = w[2*i];
        g  = w[2*i+1];
        on = (k < 4) ? r : ((k < 8) ? g : (r && g));
        return on ? MAXD : 0;
    endfunction

    // Model of one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        int          cnt;
        bit          tick;
        int          tg;
        int          nd;
        bit          nb;
        logic [11:0] nl;
        if (reset) begin
            t_since_rst = 0;
            m_soc       = 8'h00;
            m_led       = 12'h000;
            m_busy      = 1'b0;
            for (int k = 0; k < 12; k++) begin
                m_duty[k]   = 0;
                m_shadow[k] = 0;
            end
            return;
        end
        cnt  = t_since_rst % PER;
        tick = ((t_since_rst % FDIV) == FDIV - 1);
        nb   = 1'b0;
        nl   = 12'h000;
        for (int k = 0; k < 12; k++) begin
            tg    = tgt_of(m_soc, k);
            nl[k] = en && (cnt < m_shadow[k]);
            if (cnt == PER - 1) m_shadow[k] = m_duty[k];
            nd = m_duty[k];
            if (tick && m_duty[k] < tg) nd = (m_duty[k] + STP > tg) ? tg : m_duty[k] + STP;
            if (tick && m_duty[k] > tg) nd = (m_duty[k] - STP < tg) ? tg : m_duty[k] - STP;
            if (nd != tg) nb = 1'b1;
            m_duty[k] = nd;
        end
        m_led  = nl;
        m_busy = nb;
        m_soc  = soc_led;
        t_since_rst++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("led", int'(led), int'(m_led));
        chk("busy", int'(fade_busy), int'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // High cycles of each LED pin over one full PWM period.
    task automatic count_period(output int hi [12]);
        for (int k = 0; k < 12; k++) hi[k] = 0;
        for (int i = 0; i < PER; i++) begin
            step();
            for (int k = 0; k < 12; k++) hi[k] += int'(led[k]);
        end
    endtask

    task automatic wait_duty0(input int want, input string tag);
        int n;
        n = 0;
        while (m_duty[0] != want && n < 200) begin
            step();
            n++;
        end
        chk(tag, int'(n < 200), 1);
    endtask

    int hi [12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        en       = 1'b1;
        soc_led  = 8'hFF;
        @(negedge clk);

        // reset hold with all LEDs requested
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_led", int'(led), 0);
            chk("rst_busy", int'(fade_busy), 0);
        end
        reset   = 1'b0;
        soc_led = 8'h01;
        run(3);
        chk("pre_tick_busy", int'(fade_busy), 1);

        // fade up on R0 to steady state
        run(80);
        chk("up_busy_idle", int'(fade_busy), 0);
        count_period(hi);
        chk("up_r0_hi", hi[0], 12);
        chk("up_g0_hi", hi[4], 0);
        chk("up_b0_hi", hi[8], 0);

        // blue decode
        soc_led = 8'hC0;
        run(100);
        count_period(hi);
        chk("c0_r3", hi[3], 12);
        chk("c0_g3", hi[7], 12);
        chk("c0_b3", hi[11], 12);
        chk("c0_r0", hi[0], 0);
        soc_led = 8'h40;
        run(100);
        count_period(hi);
        chk("40_r3", hi[3], 12);
        chk("40_g3", hi[7], 0);
        chk("40_b3", hi[11], 0);

        // reversal mid-fade at duty 10
        soc_led = 8'h00;
        run(100);
        soc_led = 8'h01;
        wait_duty0(10, "reach_d10");
        soc_led = 8'h00;
        run(60);
        count_period(hi);
        chk("rev_r0", hi[0], 0);

        // enable gating at steady duty 12
        soc_led = 8'h01;
        run(80);
        en = 1'b0;
        run(20);
        chk("en_off_led", int'(led), 0);
        en = 1'b1;
        run(PER + 1);
        count_period(hi);
        chk("en_on_r0", hi[0], 12);

        // reset mid-fade at duty 5
        soc_led = 8'h00;
        run(80);
        soc_led = 8'h01;
        wait_duty0(5, "reach_d5");
        reset = 1'b1;
        step();
        chk("mid_rst_led", int'(led), 0);
        chk("mid_rst_busy", int'(fade_busy), 0);
        reset = 1'b0;
        run(80);
        count_period(hi);
        chk("after_rst_r0", hi[0], 12);

        // randomized stimulus
        for (int it = 0; it < 40; it++) begin
            soc_led = 8'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 14) == 0);
            step();
            reset   = 1'b0;
            run($urandom_range(5, 120));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
